// File: rtl/regfile_if.sv
// -----------------------------------------------------------------------------
// regfile_if
// Bundles the write-back write port and the two ID-stage read ports of the
// general-purpose register file.
//   we / waddr / wdata          : write port from MEM/WB
//   re1 / raddr1 / rdata1       : read port 1 (operand reg1)
//   re2 / raddr2 / rdata2       : read port 2 (operand reg2)
// Modports:
//   master : pipeline side, drives write/read requests, receives read data
//   slave  : register file side
// -----------------------------------------------------------------------------
interface regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  re1;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  re2;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic [DATA_WIDTH-1:0] rdata2;

  modport master (
    output we, waddr, wdata,
    output re1, raddr1,
    output re2, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata,
    input  re1, raddr1,
    input  re2, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
// MIPS32 general-purpose register file: NUM_REGS x DATA_WIDTH storage, one
// synchronous write port and two combinational read ports with same-cycle
// write-to-read bypass. r0 is hard-wired to zero.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset; clears storage and forces reads to 0
//   bus : regfile_if.slave (write port we/waddr/wdata, read ports re/raddr/rdata)
// -----------------------------------------------------------------------------
module regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Read-port resolution in priority order: reset, disabled port, r0,
  // bypass of the write being presented this cycle, then stored value.
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic                  rst_i,
    input logic                  en,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  we_i,
    input logic [ADDR_WIDTH-1:0] waddr_i,
    input logic [DATA_WIDTH-1:0] wdata_i,
    input logic [DATA_WIDTH-1:0] stored
  );
    logic [DATA_WIDTH-1:0] res;
    if (rst_i || !en || addr == '0) begin
      res = '0;
    end else if (we_i && addr == waddr_i) begin
      res = wdata_i;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  // Storage: r0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.we && bus.waddr != '0) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  always_comb begin
    bus.rdata1 = read_port(rst, bus.re1, bus.raddr1, bus.we, bus.waddr,
                           bus.wdata, regs[bus.raddr1]);
  end

  always_comb begin
    bus.rdata2 = read_port(rst, bus.re2, bus.raddr2, bus.we, bus.waddr,
                           bus.wdata, regs[bus.raddr2]);
  end

endmodule
